// File: rtl/fht_io_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fht_io_sequencer
// Description : Host-side sequencer for the FHT stage controller. Loads N
//               samples into four bank RAMs (bit-reversed bank addresses),
//               pulses start, waits for the controller to finish, then reads
//               the result bank set back in direct order through a small
//               output FIFO with valid/ready backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module fht_io_sequencer #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    // sample input
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    // bank write port (set A)
    output logic [D_BIT-1:0] oDATA_WR,
    output logic [A_BIT-1:0] oADDR_WR,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    // controller handshake
    output logic             oSTART,
    input  logic             iRDY,
    input  logic             iSOURCE_DATA,
    // bank read port
    output logic [A_BIT-1:0] oADDR_RD,
    output logic             oRD_SEL,
    input  logic [D_BIT-1:0] iDATA_RD_0,
    input  logic [D_BIT-1:0] iDATA_RD_1,
    input  logic [D_BIT-1:0] iDATA_RD_2,
    input  logic [D_BIT-1:0] iDATA_RD_3,
    // result output
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY
);

    localparam int               c_K_BIT = A_BIT + 2;
    localparam logic [c_K_BIT-1:0] c_LAST = '1;   // N-1

    typedef enum logic [2:0] {
        S_LOAD      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_UNLOAD    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // load side
    logic [c_K_BIT-1:0] r_k;
    logic [3:0]         r_we;
    logic [A_BIT-1:0]   r_addr_wr;
    logic [D_BIT-1:0]   r_data_wr;
    logic [A_BIT-1:0]   w_rev;
    logic               w_accept;

    // unload side
    logic [c_K_BIT-1:0] r_j;
    logic [c_K_BIT-1:0] r_out_cnt;
    logic               r_issue_done;
    logic               r_rd_sel;
    logic               r_v1;
    logic               r_v2;
    logic [1:0]         r_bank1;
    logic [1:0]         r_bank2;
    logic [D_BIT-1:0]   r_fifo_mem [4];
    logic [1:0]         r_wp;
    logic [1:0]         r_rp;
    logic [2:0]         r_cnt;
    logic [2:0]         w_occ;
    logic               w_issue;
    logic               w_empty;
    logic               w_valid;
    logic               w_pop;
    logic               w_push;
    logic               w_head_pop;
    logic [D_BIT-1:0]   w_rd_data;
    logic [D_BIT-1:0]   w_out_data;

    logic w_ready;
    logic w_start;
    logic w_busy;

    assign w_accept = iVALID & w_ready;

    // bank address is the bit-reverse of the upper write-pointer bits
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < A_BIT; i++) begin
            w_rev[i] = r_k[c_K_BIT-1-i];
        end
    end

    // state register
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        w_start = 1'b0;
        w_busy  = 1'b1;
        case (r_state)
            S_LOAD: begin
                w_ready = 1'b1;
                w_busy  = 1'b0;
                if (iVALID && (r_k == c_LAST)) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                w_start = 1'b1;
                w_next  = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!iRDY) begin
                    w_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (iRDY) begin
                    w_next = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (w_pop && (r_out_cnt == c_LAST)) begin
                    w_next = S_LOAD;
                end
            end
            default: begin
                w_next = S_LOAD;
            end
        endcase
    end

    // registered bank write, one cycle after each accepted sample
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_k       <= '0;
            r_we      <= '0;
            r_addr_wr <= '0;
            r_data_wr <= '0;
        end else begin
            r_we <= '0;
            if (w_accept) begin
                r_k       <= r_k + 1'b1;
                r_we      <= 4'b0001 << r_k[1:0];
                r_addr_wr <= w_rev;
                r_data_wr <= iDATA;
            end
        end
    end

    // occupancy including reads still in the RAM pipeline gates new reads
    assign w_occ   = r_cnt + {2'b00, r_v1} + {2'b00, r_v2};
    assign w_issue = (r_state == S_UNLOAD) && !r_issue_done && (w_occ < 3'd4);

    // read data arriving this cycle, selected by the delayed bank index
    always_comb begin
        w_rd_data = iDATA_RD_0;
        case (r_bank2)
            2'd0: w_rd_data = iDATA_RD_0;
            2'd1: w_rd_data = iDATA_RD_1;
            2'd2: w_rd_data = iDATA_RD_2;
            2'd3: w_rd_data = iDATA_RD_3;
            default: w_rd_data = iDATA_RD_0;
        endcase
    end

    // an empty FIFO passes arriving read data straight to the output
    assign w_empty    = (r_cnt == 3'd0);
    assign w_valid    = !w_empty || r_v2;
    assign w_out_data = w_empty ? w_rd_data : r_fifo_mem[r_rp];
    assign w_pop      = w_valid && iREADY;
    assign w_head_pop = w_pop && !w_empty;
    assign w_push     = r_v2 && !(w_empty && w_pop);

    // read pointer, read pipeline tracking and result-set latch
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_j          <= '0;
            r_out_cnt    <= '0;
            r_issue_done <= 1'b0;
            r_rd_sel     <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_bank1      <= '0;
            r_bank2      <= '0;
        end else begin
            if ((r_state == S_WAIT_DONE) && iRDY) begin
                r_rd_sel     <= iSOURCE_DATA;
                r_j          <= '0;
                r_out_cnt    <= '0;
                r_issue_done <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_j <= r_j + 1'b1;
                    if (r_j == c_LAST) begin
                        r_issue_done <= 1'b1;
                    end
                end
                if (w_pop) begin
                    r_out_cnt <= r_out_cnt + 1'b1;
                end
            end
            r_v1    <= w_issue;
            r_bank1 <= r_j[c_K_BIT-1:A_BIT];
            r_v2    <= r_v1;
            r_bank2 <= r_bank1;
        end
    end

    // output FIFO pointers and occupancy
    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_head_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            r_cnt <= r_cnt + {2'b00, w_push} - {2'b00, w_head_pop};
        end
    end

    // output FIFO storage
    always_ff @(posedge iCLK) begin
        if (w_push) begin
            r_fifo_mem[r_wp] <= w_rd_data;
        end
    end

    assign oREADY   = w_ready;
    assign oSTART   = w_start;
    assign oBUSY    = w_busy;
    assign oDATA_WR = r_data_wr;
    assign oADDR_WR = r_addr_wr;
    assign oWE_0    = r_we[0];
    assign oWE_1    = r_we[1];
    assign oWE_2    = r_we[2];
    assign oWE_3    = r_we[3];
    assign oADDR_RD = r_j[A_BIT-1:0];
    assign oRD_SEL  = r_rd_sel;
    assign oVALID   = w_valid;
    assign oDATA    = w_valid ? w_out_data : '0;
    assign oLAST    = w_valid && (r_out_cnt == c_LAST);

endmodule
`default_nettype wire
